// File: rtl/ctrl_sch_pkg.sv
// Shared definitions for the control output scheduler: class codes, FSM encodings,
// descriptor type and a class-to-queue one-hot helper.
package ctrl_sch_pkg;

    localparam int DESC_W = 14;

    localparam logic [1:0] CLS_TS  = 2'd0;
    localparam logic [1:0] CLS_RC  = 2'd1;
    localparam logic [1:0] CLS_BE  = 2'd2;
    localparam logic [1:0] CLS_ILL = 2'd3;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_GUARD = 2'd2;

    typedef logic [DESC_W-1:0] desc_t;

    // Queue select vector {BE,RC,TS}; the illegal class maps to no queue at all.
    function automatic logic [2:0] cls_onehot(input logic [1:0] cls);
        logic [2:0] oh;
        case (cls)
            CLS_TS:  oh = 3'b001;
            CLS_RC:  oh = 3'b010;
            CLS_BE:  oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/ctrl_sch_desc_fifo.sv
// First-word-fall-through descriptor FIFO with registered count/full/empty.
// A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
module ctrl_sch_desc_fifo
    import ctrl_sch_pkg::*;
#(
    parameter int AW = 4
)(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_push,
    input  logic [DESC_W-1:0] iv_din,
    input  logic              i_pop,
    output logic [DESC_W-1:0] ov_dout,
    output logic [AW:0]       ov_count,
    output logic              o_full,
    output logic              o_empty
);

    localparam int          DEPTH_N  = 2 ** AW;
    localparam logic [AW:0] DEPTH    = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] CNT_ZERO = {(AW+1){1'b0}};
    localparam logic [AW:0] CNT_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

    desc_t           mem_q [DEPTH_N];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            full_q, full_d;
    logic            empty_q, empty_d;
    logic            push_ok_s;
    logic            pop_ok_s;

    // Next-state pointers and occupancy.
    always_comb begin
        pop_ok_s  = i_pop && !empty_q;
        push_ok_s = i_push && (!full_q || pop_ok_s);
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        full_d  = (count_d == DEPTH);
        empty_d = (count_d == CNT_ZERO);
    end

    // Control state registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= CNT_ZERO;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage needs no reset: nothing is read while the FIFO is empty.
    always_ff @(posedge i_clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= iv_din;
        end
    end

    assign ov_dout  = mem_q[rd_ptr_q];
    assign ov_count = count_q;
    assign o_full   = full_q;
    assign o_empty  = empty_q;

endmodule

// File: rtl/control_output_schedule.sv
// Three-class (TS/RC/BE) descriptor scheduler with strict-priority, guarded issue to the TX path.
// Define CTRL_SCH_BE_AGING_EN to let a BE head waiting AGE_LIMIT cycles overtake RC for one issue.
module control_output_schedule
    import ctrl_sch_pkg::*;
#(
    parameter int QUEUE_AW  = 4,
    parameter int GUARD_CYC = 2,
    parameter int AGE_LIMIT = 256
)(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DESC_W-1:0] iv_desc,
    input  logic [1:0]        iv_desc_class,
    input  logic              i_desc_wr,
    output logic [DESC_W-1:0] ov_pkt_descriptor,
    output logic              o_pkt_descriptor_wr,
    input  logic              i_pkt_descriptor_ready,
    output logic [2:0]        ov_queue_full,
    output logic [QUEUE_AW:0] ov_ts_cnt,
    output logic [QUEUE_AW:0] ov_rc_cnt,
    output logic [QUEUE_AW:0] ov_be_cnt,
    output logic              o_drop_pulse,
    output logic [1:0]        ov_sch_state
);

    if (GUARD_CYC < 1 || GUARD_CYC > 7 || AGE_LIMIT < 1) begin : g_param_check
        $error("control_output_schedule: GUARD_CYC must be 1..7 and AGE_LIMIT >= 1");
    end

    localparam logic [2:0] GUARD_LAST = 3'(GUARD_CYC - 1);

    logic [DESC_W-1:0] head_s [3];
    logic [QUEUE_AW:0] cnt_s  [3];
    logic [2:0]        full_s;
    logic [2:0]        empty_s;
    logic [2:0]        push_s;
    logic [2:0]        pop_s;
    logic [2:0]        cls_oh_s;
    logic [1:0]        pick_s;
    logic [DESC_W-1:0] pick_head_s;
    logic              be_first_s;

    logic [1:0]        state_q, state_d;
    logic [1:0]        sel_q, sel_d;
    logic [2:0]        guard_q, guard_d;
    logic              wr_q, wr_d;
    logic [DESC_W-1:0] desc_q, desc_d;
    logic              drop_q, drop_d;

    for (genvar g = 0; g < 3; g++) begin : g_queue
        ctrl_sch_desc_fifo #(.AW(QUEUE_AW)) u_fifo (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_push  (push_s[g]),
            .iv_din  (iv_desc),
            .i_pop   (pop_s[g]),
            .ov_dout (head_s[g]),
            .ov_count(cnt_s[g]),
            .o_full  (full_s[g]),
            .o_empty (empty_s[g])
        );
    end

    // Enqueue demux and drop detection; the pop is known before the push is judged.
    always_comb begin
        pop_s    = (state_q == S_ISSUE) ? cls_onehot(sel_q) : 3'b000;
        cls_oh_s = cls_onehot(iv_desc_class);
        push_s   = 3'b000;
        drop_d   = 1'b0;
        if (i_desc_wr) begin
            if (cls_oh_s == 3'b000) begin
                drop_d = 1'b1;
            end else if ((cls_oh_s & full_s & ~pop_s) != 3'b000) begin
                drop_d = 1'b1;
            end else begin
                push_s = cls_oh_s;
            end
        end else begin
            drop_d = 1'b0;
        end
    end

`ifdef CTRL_SCH_BE_AGING_EN
    localparam int              AGE_W   = $clog2(AGE_LIMIT + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(AGE_LIMIT);
    localparam logic [AGE_W-1:0] AGE_ONE = AGE_W'(1);

    logic [AGE_W-1:0] age_q, age_d;

    // BE head wait time, saturating; cleared on BE issue or when BE drains.
    always_comb begin
        if (pop_s[2] || empty_s[2]) begin
            age_d = {AGE_W{1'b0}};
        end else if (age_q == AGE_MAX) begin
            age_d = age_q;
        end else begin
            age_d = age_q + AGE_ONE;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            age_q <= {AGE_W{1'b0}};
        end else begin
            age_q <= age_d;
        end
    end

    assign be_first_s = (age_q == AGE_MAX);
`else
    assign be_first_s = 1'b0;
`endif

    // Priority pick: TS first, then RC, unless an aged BE head jumps ahead of RC.
    always_comb begin
        if (!empty_s[0]) begin
            pick_s = CLS_TS;
        end else if (be_first_s && !empty_s[2]) begin
            pick_s = CLS_BE;
        end else if (!empty_s[1]) begin
            pick_s = CLS_RC;
        end else begin
            pick_s = CLS_BE;
        end
        case (pick_s)
            CLS_TS:  pick_head_s = head_s[0];
            CLS_RC:  pick_head_s = head_s[1];
            default: pick_head_s = head_s[2];
        endcase
    end

    // Issue FSM: the descriptor and strobe are registered on IDLE->ISSUE so wr coincides with ISSUE.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        guard_d = guard_q;
        wr_d    = 1'b0;
        desc_d  = desc_q;
        case (state_q)
            S_IDLE: begin
                if (i_pkt_descriptor_ready && (empty_s != 3'b111)) begin
                    state_d = S_ISSUE;
                    sel_d   = pick_s;
                    wr_d    = 1'b1;
                    desc_d  = pick_head_s;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                state_d = S_GUARD;
                guard_d = 3'd0;
            end
            S_GUARD: begin
                if (guard_q == GUARD_LAST) begin
                    state_d = S_IDLE;
                    guard_d = 3'd0;
                end else begin
                    guard_d = guard_q + 3'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                guard_d = 3'd0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            sel_q   <= CLS_TS;
            guard_q <= 3'd0;
            wr_q    <= 1'b0;
            desc_q  <= {DESC_W{1'b0}};
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            guard_q <= guard_d;
            wr_q    <= wr_d;
            desc_q  <= desc_d;
            drop_q  <= drop_d;
        end
    end

    assign ov_pkt_descriptor   = desc_q;
    assign o_pkt_descriptor_wr = wr_q;
    assign o_drop_pulse        = drop_q;
    assign ov_sch_state        = state_q;
    assign ov_queue_full       = full_s;
    assign ov_ts_cnt           = cnt_s[0];
    assign ov_rc_cnt           = cnt_s[1];
    assign ov_be_cnt           = cnt_s[2];

endmodule

// File: tb/tb_control_output_schedule.sv
// Self-checking bench for control_output_schedule: queue-based reference model compared every
// cycle, plus directed scenarios with literal expectations. Honours CTRL_SCH_BE_AGING_EN.
module tb_control_output_schedule;

    localparam int G     = 2;
    localparam int AGE   = 8;
    localparam int DEPTH = 16;
`ifdef CTRL_SCH_BE_AGING_EN
    localparam int AGING = 1;
`else
    localparam int AGING = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [13:0] desc_in = 14'd0;
    logic [1:0]  cls_in = 2'd0;
    logic        wr_in = 1'b0;
    logic        ready = 1'b0;

    logic [13:0] o_desc;
    logic        o_wr;
    logic [2:0]  o_full;
    logic [4:0]  o_ts, o_rc, o_be;
    logic        o_drop;
    logic [1:0]  o_state;

    control_output_schedule #(.QUEUE_AW(4), .GUARD_CYC(G), .AGE_LIMIT(AGE)) dut (
        .i_clk                 (clk),
        .i_rst                 (rst),
        .iv_desc               (desc_in),
        .iv_desc_class         (cls_in),
        .i_desc_wr             (wr_in),
        .ov_pkt_descriptor     (o_desc),
        .o_pkt_descriptor_wr   (o_wr),
        .i_pkt_descriptor_ready(ready),
        .ov_queue_full         (o_full),
        .ov_ts_cnt             (o_ts),
        .ov_rc_cnt             (o_rc),
        .ov_be_cnt             (o_be),
        .o_drop_pulse          (o_drop),
        .ov_sch_state          (o_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: three plain queues plus a cooldown timer (G+1 = issuing, 1..G = guard, 0 = idle).
    logic [13:0] qts[$];
    logic [13:0] qrc[$];
    logic [13:0] qbe[$];
    int          m_cool = 0;
    int          m_sel = 0;
    int          m_age = 0;
    int          e_wr = 0, e_desc = 0, e_state = 0, e_drop = 0, e_full = 0;
    int          e_ts = 0, e_rc = 0, e_be = 0;

    logic [13:0] ev_desc[$];
    int          ev_cyc[$];
    int          n_drop_seen = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int qsize(input int c);
        case (c)
            0:       return qts.size();
            1:       return qrc.size();
            default: return qbe.size();
        endcase
    endfunction

    function automatic logic [13:0] qhead(input int c);
        case (c)
            0:       return qts[0];
            1:       return qrc[0];
            default: return qbe[0];
        endcase
    endfunction

    task automatic model_reset();
        qts.delete(); qrc.delete(); qbe.delete();
        m_cool = 0; m_sel = 0; m_age = 0;
        e_wr = 0; e_desc = 0; e_state = 0; e_drop = 0; e_full = 0;
        e_ts = 0; e_rc = 0; e_be = 0;
    endtask

    // Predicts the outputs after the coming rising edge from the inputs now stable.
    task automatic model_step();
        int sz[3];
        bit pop[3];
        int pick;
        int c;
        logic [13:0] hd;
        for (int k = 0; k < 3; k++) begin
            sz[k] = qsize(k);
            pop[k] = 1'b0;
        end
        if (m_cool == G + 1) pop[m_sel] = 1'b1;
        pick = -1;
        hd = 14'(e_desc);
        if (m_cool == 0 && ready && (sz[0] + sz[1] + sz[2]) > 0) begin
            if (sz[0] > 0) pick = 0;
            else if (AGING == 1 && m_age >= AGE && sz[2] > 0) pick = 2;
            else if (sz[1] > 0) pick = 1;
            else pick = 2;
            hd = qhead(pick);
        end
        if (AGING == 1) m_age = (pop[2] || sz[2] == 0) ? 0 : ((m_age < AGE) ? m_age + 1 : AGE);
        if (pop[0]) void'(qts.pop_front());
        if (pop[1]) void'(qrc.pop_front());
        if (pop[2]) void'(qbe.pop_front());
        e_drop = 0;
        if (wr_in) begin
            c = int'(cls_in);
            if (c == 3) e_drop = 1;
            else if (sz[c] >= DEPTH && !pop[c]) e_drop = 1;
            else if (c == 0) qts.push_back(desc_in);
            else if (c == 1) qrc.push_back(desc_in);
            else qbe.push_back(desc_in);
        end
        if (pick >= 0) begin
            m_cool = G + 1;
            m_sel = pick;
        end else if (m_cool > 0) begin
            m_cool = m_cool - 1;
        end
        e_wr = (m_cool == G + 1) ? 1 : 0;
        e_state = (m_cool == 0) ? 0 : ((m_cool == G + 1) ? 1 : 2);
        e_desc = int'(hd);
        e_ts = qts.size(); e_rc = qrc.size(); e_be = qbe.size();
        e_full = ((e_be == DEPTH) ? 4 : 0) + ((e_rc == DEPTH) ? 2 : 0) + ((e_ts == DEPTH) ? 1 : 0);
    endtask

    // Compare process: check last prediction on the falling edge, then predict the next edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                model_reset();
            end else begin
                chk("wr", int'(o_wr), e_wr);
                chk("desc", int'(o_desc), e_desc);
                chk("state", int'(o_state), e_state);
                chk("ts_cnt", int'(o_ts), e_ts);
                chk("rc_cnt", int'(o_rc), e_rc);
                chk("be_cnt", int'(o_be), e_be);
                chk("full", int'(o_full), e_full);
                chk("drop", int'(o_drop), e_drop);
                if (o_wr) begin
                    ev_desc.push_back(o_desc);
                    ev_cyc.push_back(cyc);
                end
                if (o_drop) n_drop_seen++;
                model_step();
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_desc(input logic [1:0] c, input logic [13:0] d);
        cls_in = c;
        desc_in = d;
        wr_in = 1'b1;
        tick();
        wr_in = 1'b0;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        ready = 1'b1;
        for (int k = 0; k < 300 && !done; k++) begin
            tick();
            if (qts.size() == 0 && qrc.size() == 0 && qbe.size() == 0 && m_cool == 0) done = 1'b1;
        end
        ready = 1'b0;
        chk("drain_done", int'(done), 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wr"}, int'(o_wr), 0);
        chk({tag, "_desc"}, int'(o_desc), 0);
        chk({tag, "_state"}, int'(o_state), 0);
        chk({tag, "_cnts"}, int'(o_ts) + int'(o_rc) + int'(o_be), 0);
        chk({tag, "_full"}, int'(o_full), 0);
        chk({tag, "_drop"}, int'(o_drop), 0);
    endtask

    initial begin
        int n0, d0;
        bit found, be_seen;

        repeat (3) tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();

        // 1: priority order and spacing; writes land while ready is low so all three compete.
        ev_desc.delete(); ev_cyc.delete();
        wr_desc(2'd2, 14'h0005);
        wr_desc(2'd1, 14'h0203);
        wr_desc(2'd0, 14'h1C01);
        ready = 1'b1;
        repeat (20) tick();
        ready = 1'b0;
        chk("t1_issue_count", ev_desc.size(), 3);
        if (ev_desc.size() == 3) begin
            chk("t1_first", int'(ev_desc[0]), 'h1C01);
            chk("t1_second", int'(ev_desc[1]), 'h0203);
            chk("t1_third", int'(ev_desc[2]), 'h0005);
            chk("t1_space_a", ev_cyc[1] - ev_cyc[0], 4);
            chk("t1_space_b", ev_cyc[2] - ev_cyc[1], 4);
        end

        // 3: illegal class is dropped, nothing stored, nothing issued.
        n0 = ev_desc.size();
        wr_desc(2'd3, 14'h3FFF);
        chk("t3_drop", int'(o_drop), 1);
        chk("t3_cnts", int'(o_ts) + int'(o_rc) + int'(o_be), 0);
        tick();
        chk("t3_no_wr", ev_desc.size() - n0, 0);

        // 2: overfill TS with ready low.
        n0 = ev_desc.size();
        d0 = n_drop_seen;
        for (int i = 0; i < 17; i++) wr_desc(2'd0, 14'(14'h0100 + 14'(i)));
        tick();
        chk("t2_ts_cnt", int'(o_ts), 16);
        chk("t2_full", int'(o_full), 3'b001);
        chk("t2_drops", n_drop_seen - d0, 1);
        chk("t2_no_wr", ev_desc.size() - n0, 0);

        // 4: enqueue into the full TS queue during its ISSUE cycle.
        ready = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            tick();
            if (o_state == 2'd1) found = 1'b1;
        end
        chk("t4_issue_seen", int'(found), 1);
        ready = 1'b0;
        wr_desc(2'd0, 14'h2222);
        chk("t4_no_drop", int'(o_drop), 0);
        chk("t4_ts_cnt", int'(o_ts), 16);
        drain();

        // 5: reset during GUARD with three descriptors still queued.
        wr_desc(2'd0, 14'h0011);
        wr_desc(2'd0, 14'h0012);
        wr_desc(2'd1, 14'h0213);
        wr_desc(2'd2, 14'h0414);
        ready = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            tick();
            if (o_state == 2'd2) found = 1'b1;
        end
        chk("t5_guard_seen", int'(found), 1);
        rst = 1'b1;
        #1;
        chk_all_zero("t5_rst");
        ready = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        ready = 1'b1;
        n0 = ev_desc.size();
        repeat (10) tick();
        chk("t5_no_wr", ev_desc.size() - n0, 0);
        chk("t5_cnts", int'(o_ts) + int'(o_rc) + int'(o_be), 0);
        wr_desc(2'd0, 14'h0055);
        repeat (3) tick();
        chk("t5_new_issue", ev_desc.size() - n0, 1);
        drain();

        // 6: steady RC stream with one BE waiting.
        wr_desc(2'd1, 14'h0301);
        wr_desc(2'd1, 14'h0302);
        wr_desc(2'd1, 14'h0303);
        ready = 1'b1;
        n0 = ev_desc.size();
        for (int i = 0; i < 60; i++) begin
            if (i % 4 == 0) wr_desc(2'd1, 14'(14'h0310 + 14'(i)));
            else if (i == 5) wr_desc(2'd2, 14'h0555);
            else tick();
        end
        be_seen = 1'b0;
        for (int k = n0; k < ev_desc.size(); k++) begin
            if (ev_desc[k] == 14'h0555) be_seen = 1'b1;
        end
        chk("t6_be_issued", int'(be_seen), AGING);
        chk("t6_rc_busy", int'(o_rc != 5'd0), 1);
        ready = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
